i2c_slave_sequencer: RTL and testbench

I2C_SLAVE_SEQUENCER -- requirements
Module: i2c_slave_sequencer

---
 rtl/i2c_slave_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_slave_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_slave_sequencer: I2C slave bit/byte sequencer (addr, rx, tx, ack)        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module i2c_slave_sequencer #(
  parameter logic [7:0] TX_FILL = 8'hFF
) (
  input  logic       FPGA_clk,
  input  logic       rst_n,
  input  logic       SCL,
  input  logic       SDA,
  input  logic       addr_done,
  input  logic       addr_selected,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       SCL_prev,
  output logic       addr_enable,
  output logic       addr_rst,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_ready,
  output logic       rw,
  output logic       busy,
  output logic       tx_underrun
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    RW_BIT    = 4'd2,
    ADDR_ACK  = 4'd3,
    RX_BYTE   = 4'd4,
    RX_ACK    = 4'd5,
    TX_BYTE   = 4'd6,
    TX_ACK    = 4'd7,
    WAIT_STOP = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addr_enable_q, addr_enable_d;
  logic       addr_rst_q, addr_rst_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
  logic       tx_underrun_q, tx_underrun_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_sr_q, tx_sr_d;

  logic       w_rise, w_fall, w_start, w_stop, w_load;
  logic [7:0] w_tx_byte;

  assign w_rise    = !scl_prev_q && SCL;
  assign w_fall    = scl_prev_q && !SCL;
  assign w_start   = scl_prev_q && SCL && sda_prev_q && !SDA;
  assign w_stop    = scl_prev_q && SCL && !sda_prev_q && SDA;
  assign w_tx_byte = tx_valid ? tx_data : TX_FILL;

  always_comb begin
    state_d       = state_q;
    scl_prev_d    = SCL;
    sda_prev_d    = SDA;
    sda_oe_d      = sda_oe_q;
    addr_rst_d    = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_ready_d    = 1'b0;
    tx_underrun_d = 1'b0;
    rw_d          = rw_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    shift_d       = shift_q;
    tx_sr_d       = tx_sr_q;
    w_load        = 1'b0;

    if (w_start) begin
      state_d    = ADDR;
      addr_rst_d = 1'b1;
      sda_oe_d   = 1'b0;
      cnt_d      = 3'd0;
      pending_d  = 1'b0;
      shift_d    = 8'h00;
    end else if (w_stop) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      cnt_d     = 3'd0;
      pending_d = 1'b0;
    end else begin
      // pending_q marks "sampled on the rise, waiting for the closing fall"
      case (state_q)
        ADDR: begin
          if (addr_done) begin
            state_d   = RW_BIT;
            pending_d = 1'b0;
          end
        end
        RW_BIT: begin
          if (w_rise) begin
            rw_d      = SDA;
            pending_d = 1'b1;
          end else if (w_fall && pending_q) begin
            pending_d = 1'b0;
            state_d   = addr_selected ? ADDR_ACK : WAIT_STOP;
            sda_oe_d  = addr_selected;
          end
        end
        ADDR_ACK: begin
          if (w_fall) begin
            cnt_d = 3'd0;
            if (rw_q) begin
              w_load = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (w_rise) begin
            shift_d = {shift_q[6:0], SDA};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], SDA};
              rx_valid_d = 1'b1;
              pending_d  = 1'b1;
            end
          end else if (w_fall && pending_q) begin
            pending_d = 1'b0;
            sda_oe_d  = 1'b1;
            state_d   = RX_ACK;
          end
        end
        RX_ACK: begin
          if (w_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (w_fall) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = TX_ACK;
            end else begin
              sda_oe_d = !tx_sr_q[6];
            end
          end
        end
        TX_ACK: begin
          if (w_rise) begin
            if (!SDA) begin
              pending_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (w_fall && pending_q) begin
            pending_d = 1'b0;
            w_load    = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    if (w_load) begin
      tx_sr_d       = w_tx_byte;
      sda_oe_d      = !w_tx_byte[7];
      tx_ready_d    = tx_valid;
      tx_underrun_d = !tx_valid;
      cnt_d         = 3'd0;
      state_d       = TX_BYTE;
    end

    addr_enable_d = (state_d == ADDR);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      sda_oe_q      <= 1'b0;
      addr_enable_q <= 1'b0;
      addr_rst_q    <= 1'b1;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rw_q          <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= 3'd0;
      pending_q     <= 1'b0;
      shift_q       <= 8'h00;
      tx_sr_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      scl_prev_q    <= scl_prev_d;
      sda_prev_q    <= sda_prev_d;
      sda_oe_q      <= sda_oe_d;
      addr_enable_q <= addr_enable_d;
      addr_rst_q    <= addr_rst_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      rw_q          <= rw_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      shift_q       <= shift_d;
      tx_sr_q       <= tx_sr_d;
    end
  end

  assign SCL_prev    = scl_prev_q;
  assign addr_enable = addr_enable_q;
  assign addr_rst    = addr_rst_q;
  assign sda_oe      = sda_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign rw          = rw_q;
  assign busy        = busy_q;
  assign tx_underrun = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_slave_sequencer: bus-level bench with a frame-position model          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_i2c_slave_sequencer;

  localparam int H = 4;

  logic       FPGA_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       SCL      = 1'b1;
  logic       sda_m    = 1'b1;
  logic       SDA;
  logic       addr_done     = 1'b0;
  logic       addr_selected = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       SCL_prev, addr_enable, addr_rst, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready, rw, busy, tx_underrun;

  int n_checks = 0;
  int n_err    = 0;

  assign SDA = sda_m & ~sda_oe;

  always #5 FPGA_clk = ~FPGA_clk;

  i2c_slave_sequencer #(.TX_FILL(8'hFF)) dut (
    .FPGA_clk(FPGA_clk), .rst_n(rst_n), .SCL(SCL), .SDA(SDA),
    .addr_done(addr_done), .addr_selected(addr_selected),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .SCL_prev(SCL_prev), .addr_enable(addr_enable), .addr_rst(addr_rst),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .rw(rw), .busy(busy), .tx_underrun(tx_underrun)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expected outputs follow from the position within the frame,
  // counted as SCL rises/falls since the last START.
  logic       m_scl_p, m_sda_p, m_act, m_sel, m_nack;
  int         m_r, m_f, t_r, t_f, t_p;
  logic [7:0] m_acc, m_cur, t_b;
  logic       e_oe, e_busy, e_aen, e_arst, e_rxv, e_txr, e_txu, e_rw;
  logic [7:0] e_rxd;

  always @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scl_p <= 1'b1; m_sda_p <= 1'b1; m_act <= 1'b0; m_sel <= 1'b0; m_nack <= 1'b0;
      m_r <= 0; m_f <= 0; m_acc <= 8'h00; m_cur <= 8'h00;
      e_oe <= 1'b0; e_busy <= 1'b0; e_aen <= 1'b0; e_arst <= 1'b1;
      e_rxv <= 1'b0; e_txr <= 1'b0; e_txu <= 1'b0; e_rw <= 1'b0; e_rxd <= 8'h00;
    end else begin
      m_scl_p <= SCL; m_sda_p <= SDA;
      e_arst <= 1'b0; e_rxv <= 1'b0; e_txr <= 1'b0; e_txu <= 1'b0;
      if (m_scl_p && SCL && m_sda_p && !SDA) begin
        m_act <= 1'b1; m_r <= 0; m_f <= 0; m_sel <= 1'b0; m_nack <= 1'b0;
        e_oe <= 1'b0; e_arst <= 1'b1; e_aen <= 1'b1; e_busy <= 1'b1;
      end else if (m_scl_p && SCL && !m_sda_p && SDA) begin
        m_act <= 1'b0; e_oe <= 1'b0; e_aen <= 1'b0; e_busy <= 1'b0;
      end else if (m_act) begin
        if (e_aen && addr_done) e_aen <= 1'b0;
        if (!m_scl_p && SCL) begin
          t_r = m_r + 1;
          m_r <= t_r;
          if (t_r == 8) begin
            e_rw <= SDA;
          end else if (t_r > 9 && m_sel && !e_rw && ((t_r - 1) % 9) < 8) begin
            m_acc <= {m_acc[6:0], SDA};
            if (((t_r - 1) % 9) == 7) begin
              e_rxv <= 1'b1;
              e_rxd <= {m_acc[6:0], SDA};
            end
          end else if (t_r > 9 && m_sel && e_rw && (t_r % 9) == 0 && SDA) begin
            m_nack <= 1'b1;
          end
        end
        if (m_scl_p && !SCL) begin
          t_f = m_f + 1;
          m_f <= t_f;
          if (t_f == 9) begin
            m_sel <= addr_selected;
            e_oe  <= addr_selected;
          end else if (t_f > 9 && m_sel && !e_rw) begin
            e_oe <= ((t_f % 9) == 0);
          end else if (t_f > 9 && m_sel && e_rw && !m_nack) begin
            t_p = (t_f - 1) % 9;
            if (t_p == 0) begin
              t_b = tx_valid ? tx_data : 8'hFF;
              m_cur <= t_b;
              e_txr <= tx_valid;
              e_txu <= !tx_valid;
              e_oe  <= !t_b[7];
            end else if (t_p < 8) begin
              e_oe <= !m_cur[7 - t_p];
            end else begin
              e_oe <= 1'b0;
            end
          end else begin
            e_oe <= 1'b0;
          end
        end
      end
    end
  end

  int c_rxv = 0, c_txr = 0, c_txu = 0, c_oe = 0, c_arst = 0;

  always @(negedge FPGA_clk) begin
    if (rst_n) begin
      chk("sda_oe", {7'd0, sda_oe}, {7'd0, e_oe});
      chk("busy", {7'd0, busy}, {7'd0, e_busy});
      chk("addr_enable", {7'd0, addr_enable}, {7'd0, e_aen});
      chk("addr_rst", {7'd0, addr_rst}, {7'd0, e_arst});
      chk("rx_valid", {7'd0, rx_valid}, {7'd0, e_rxv});
      chk("rx_data", rx_data, e_rxd);
      chk("tx_ready", {7'd0, tx_ready}, {7'd0, e_txr});
      chk("tx_underrun", {7'd0, tx_underrun}, {7'd0, e_txu});
      chk("rw", {7'd0, rw}, {7'd0, e_rw});
      chk("SCL_prev", {7'd0, SCL_prev}, {7'd0, m_scl_p});
      c_rxv  += int'(rx_valid);
      c_txr  += int'(tx_ready);
      c_txu  += int'(tx_underrun);
      c_oe   += int'(sda_oe);
      c_arst += int'(addr_rst);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge FPGA_clk);
    #2;
  endtask

  task automatic bus_bit(input logic b, output logic got);
    sda_m = b; hold(H);
    SCL = 1'b1; hold(H);
    got = SDA;
    SCL = 1'b0; hold(H);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; hold(H);
    SCL = 1'b1; hold(H);
    sda_m = 1'b0; hold(H);
    SCL = 1'b0; hold(H);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; hold(H);
    SCL = 1'b1; hold(H);
    sda_m = 1'b1; hold(H);
  endtask

  task automatic addr_phase(input logic rwb, output logic ack);
    logic [6:0] a;
    logic g;
    a = 7'h50;
    for (int i = 6; i >= 0; i--) bus_bit(a[i], g);
    addr_done = 1'b1; hold(1); addr_done = 1'b0;
    bus_bit(rwb, g);
    bus_bit(1'b1, ack);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], g);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] v);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, g);
      v[i] = g;
    end
    bus_bit(!ack_m, g);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] v;
    int         s0, s1, s2;

    hold(3);
    chk("rst sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("rst addr_enable", {7'd0, addr_enable}, 8'h00);
    chk("rst addr_rst", {7'd0, addr_rst}, 8'h01);
    chk("rst rx_data", rx_data, 8'h00);
    chk("rst pulses", {5'd0, rx_valid, tx_ready, tx_underrun}, 8'h00);
    chk("rst rw_busy", {6'd0, rw, busy}, 8'h00);
    chk("rst SCL_prev", {7'd0, SCL_prev}, 8'h01);
    rst_n = 1'b1;
    hold(3);

    // Write 0x5A to a matching address
    addr_selected = 1'b1;
    s0 = c_rxv;
    bus_start;
    addr_phase(1'b0, ack);
    chk("wr addr ack", {7'd0, ack}, 8'h00);
    write_byte(8'h5A, ack);
    chk("wr data ack", {7'd0, ack}, 8'h00);
    chk("wr rx_data", rx_data, 8'h5A);
    chk("wr rx_valid pulses", 8'(c_rxv - s0), 8'd1);
    bus_stop;
    hold(2);
    chk("wr busy after stop", {7'd0, busy}, 8'h00);

    // Read 0xC3 twice, master ACK then NACK
    tx_valid = 1'b1; tx_data = 8'hC3;
    s0 = c_txr; s1 = c_txu;
    bus_start;
    addr_phase(1'b1, ack);
    chk("rd addr ack", {7'd0, ack}, 8'h00);
    read_byte(1'b1, v);
    chk("rd byte1", v, 8'hC3);
    read_byte(1'b0, v);
    chk("rd byte2", v, 8'hC3);
    bus_stop;
    chk("rd tx_ready pulses", 8'(c_txr - s0), 8'd2);
    chk("rd underrun pulses", 8'(c_txu - s1), 8'd0);

    // Read with no valid tx data
    tx_valid = 1'b0;
    s0 = c_txr; s1 = c_txu;
    bus_start;
    addr_phase(1'b1, ack);
    read_byte(1'b0, v);
    chk("ur byte", v, 8'hFF);
    bus_stop;
    chk("ur underrun pulses", 8'(c_txu - s1), 8'd1);
    chk("ur tx_ready pulses", 8'(c_txr - s0), 8'd0);

    // Address mismatch: never drive SDA
    addr_selected = 1'b0;
    s0 = c_oe; s1 = c_rxv;
    bus_start;
    addr_phase(1'b0, ack);
    chk("mm addr ack", {7'd0, ack}, 8'h01);
    write_byte(8'h33, ack);
    write_byte(8'hCC, ack);
    chk("mm data ack", {7'd0, ack}, 8'h01);
    chk("mm busy", {7'd0, busy}, 8'h01);
    chk("mm oe cycles", 8'(c_oe - s0), 8'd0);
    chk("mm rx_valid", 8'(c_rxv - s1), 8'd0);
    bus_stop;
    hold(2);
    chk("mm busy after stop", {7'd0, busy}, 8'h00);

    // Repeated START after 4 data bits
    addr_selected = 1'b1;
    bus_start;
    addr_phase(1'b0, ack);
    s0 = c_rxv; s1 = c_arst;
    bus_bit(1'b1, ack); bus_bit(1'b0, ack); bus_bit(1'b1, ack); bus_bit(1'b1, ack);
    bus_start;
    chk("rs addr_rst pulses", 8'(c_arst - s1), 8'd1);
    chk("rs addr_enable", {7'd0, addr_enable}, 8'h01);
    chk("rs no rx_valid", 8'(c_rxv - s0), 8'd0);
    addr_phase(1'b0, ack);
    write_byte(8'h12, ack);
    chk("rs rx_data", rx_data, 8'h12);
    chk("rs rx_valid", 8'(c_rxv - s0), 8'd1);
    bus_stop;

    // Reset while driving a zero bit
    tx_valid = 1'b1; tx_data = 8'h00;
    bus_start;
    addr_phase(1'b1, ack);
    sda_m = 1'b1; hold(1);
    chk("mr oe before rst", {7'd0, sda_oe}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("mr oe async", {7'd0, sda_oe}, 8'h00);
    chk("mr busy async", {7'd0, busy}, 8'h00);
    chk("mr addr_rst async", {7'd0, addr_rst}, 8'h01);
    hold(2);
    rst_n = 1'b1;
    s0 = c_oe; s2 = c_txr;
    bus_bit(1'b1, ack); bus_bit(1'b0, ack); bus_bit(1'b1, ack);
    chk("mr idle busy", {7'd0, busy}, 8'h00);
    chk("mr idle oe cycles", 8'(c_oe - s0), 8'd0);
    chk("mr idle tx_ready", 8'(c_txr - s2), 8'd0);
    bus_stop;
    s0 = c_rxv;
    bus_start;
    addr_phase(1'b0, ack);
    write_byte(8'hA5, ack);
    chk("mr recover rx_data", rx_data, 8'hA5);
    chk("mr recover rx_valid", 8'(c_rxv - s0), 8'd1);
    bus_stop;
    hold(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
